seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_driver.sv | 148 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexes six packed BCD digits onto one active-low
// 7-segment bus with active-low one-hot digit selects. Every digit slot
// starts with a dead-time gap so neighbouring digits never ghost. The
// digits are captured once per frame so a carry ripple cannot tear the
// display mid-frame.
//
// Optional feature macro: SEG_SCAN_LZ_BLANK_EN
//   defined   -> the hours-tens digit (last digit) stays dark when it is 0
//   undefined -> the hours-tens digit shows 0 like every other digit
module seg_scan_driver #(
  parameter int CLK_FREQ = 50000000,
  parameter int SCAN_HZ  = 1000,
  parameter int DEAD_CYC = 500,
  parameter int DIGITS   = 6
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int SLOT  = CLK_FREQ / SCAN_HZ;
  localparam int CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT - 1);
  localparam logic [CNT_W-1:0] DEAD_LIM  = CNT_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // A zero-length dead time means the slot opens straight into SHOW.
  localparam state_t RST_STATE = (DEAD_CYC > 0) ? BLANK : SHOW;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [6:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     dig_sel_q, dig_sel_d;
  logic                  frame_done_q, frame_done_d;
  logic [3:0]            cur_digit;

  // BCD to active-low gfedcba; anything outside 0..9 shows a dash.
  function automatic logic [6:0] decode_bcd(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Pick the frozen digit addressed by the current scan index.
  always_comb begin
    cur_digit = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_digit = shadow_q[4*k +: 4];
      end
    end
  end

  // Next-state and registered-output logic for the scan.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    seg_d        = 7'h7F;
    dig_sel_d    = '1;
    frame_done_d = 1'b0;

    if (en) begin
      if ((cnt_q == '0) && (idx_q == '0)) begin
        shadow_d = bcd_in;
      end

      if (cnt_q == SLOT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      frame_done_d = (cnt_q == SLOT_LAST) && (idx_q == IDX_LAST);

      if (state_q == SHOW) begin
        seg_d = decode_bcd(cur_digit);
        for (int k = 0; k < DIGITS; k++) begin
          dig_sel_d[k] = (idx_q != IDX_W'(k));
        end
`ifdef SEG_SCAN_LZ_BLANK_EN
        if ((idx_q == IDX_LAST) && (cur_digit == 4'd0)) begin
          seg_d     = 7'h7F;
          dig_sel_d = '1;
        end
`endif
      end
    end else begin
      cnt_d = '0;
      idx_d = '0;
    end

    state_d = (cnt_d < DEAD_LIM) ? BLANK : SHOW;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q      <= RST_STATE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      seg_q        <= 7'h7F;
      dig_sel_q    <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      seg_q        <= seg_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dig_sel    = dig_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with a small scan geometry:
// SLOT = 10 cycles, DEAD_CYC = 2, six digits, so one frame is 60 cycles.
// Output cycle m counts edges from the first enabled edge of a frame.
module tb_seg_scan_driver;

  localparam int CLK_FREQ = 100;
  localparam int SCAN_HZ  = 10;
  localparam int DEAD_CYC = 2;
  localparam int DIGITS   = 6;

  logic        clk50m = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] bcdIn;
  logic [6:0]  seg;
  logic [5:0]  digSel;
  logic        frameDone;

  int checkCount = 0;
  int errorCount = 0;

  seg_scan_driver #(
    .CLK_FREQ (CLK_FREQ),
    .SCAN_HZ  (SCAN_HZ),
    .DEAD_CYC (DEAD_CYC),
    .DIGITS   (DIGITS)
  ) dut (
    .clk_50m    (clk50m),
    .rst        (rst),
    .en         (en),
    .bcd_in     (bcdIn),
    .seg        (seg),
    .dig_sel    (digSel),
    .frame_done (frameDone)
  );

  always #5 clk50m = ~clk50m;

  // Counts one comparison and reports it when it does not match.
  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Drives inputs, then advances one edge and settles just after it.
  task automatic applyStimulus(input logic r, input logic e, input logic [23:0] b);
    rst   = r;
    en    = e;
    bcdIn = b;
    @(posedge clk50m);
    #1;
  endtask

  // Expected active-low gfedcba pattern, straight from the decode table.
  function automatic logic [7:0] segFor(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = 8'h40;
      4'd1:    s = 8'h79;
      4'd2:    s = 8'h24;
      4'd3:    s = 8'h30;
      4'd4:    s = 8'h19;
      4'd5:    s = 8'h12;
      4'd6:    s = 8'h02;
      4'd7:    s = 8'h78;
      4'd8:    s = 8'h00;
      4'd9:    s = 8'h18;
      default: s = 8'h3F;
    endcase
    return s;
  endfunction

  task automatic checkDark(input string tag);
    checkOutput({tag, "_seg"}, {1'b0, seg}, 8'h7F);
    checkOutput({tag, "_dig"}, {2'b00, digSel}, 8'h3F);
    checkOutput({tag, "_fd"}, {7'b0, frameDone}, 8'h00);
  endtask

  // Expected outputs at output cycle m of a frame showing the given digits.
  task automatic checkScan(input string tag, input int m, input logic [23:0] shown);
    int         c;
    int         i;
    logic [3:0] d;
    logic [7:0] expSeg;
    logic [7:0] expDig;
    c = (m - 1) % 10;
    i = ((m - 1) / 10) % 6;
    d = shown[4*i +: 4];
    if (c < DEAD_CYC) begin
      expSeg = 8'h7F;
      expDig = 8'h3F;
    end else begin
      expSeg = segFor(d);
      expDig = 8'h3F & ~(8'h01 << i);
`ifdef SEG_SCAN_LZ_BLANK_EN
      if (i == 5 && d == 4'd0) begin
        expSeg = 8'h7F;
        expDig = 8'h3F;
      end
`endif
    end
    checkOutput($sformatf("%s_seg_m%0d", tag, m), {1'b0, seg}, expSeg);
    checkOutput($sformatf("%s_dig_m%0d", tag, m), {2'b00, digSel}, expDig);
    checkOutput($sformatf("%s_fd_m%0d", tag, m), {7'b0, frameDone},
                (m % 60 == 0) ? 8'h01 : 8'h00);
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    bcdIn = 24'h123456;

    $display("[TB] reset phase");
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b1, 1'b1, 24'h123456);
      checkDark($sformatf("reset%0d", n));
    end

    $display("[TB] basic scan and anti-tear");
    for (int m = 1; m <= 120; m++) begin
      applyStimulus(1'b0, 1'b1, (m >= 26) ? 24'h999999 : 24'h123456);
      checkScan("scan", ((m - 1) % 60) + 1, (m <= 60) ? 24'h123456 : 24'h999999);
      if (m == 3) begin
        checkOutput("hand_dig_m3", {2'b00, digSel}, 8'h3E);
        checkOutput("hand_seg_m3", {1'b0, seg}, 8'h02);
      end
      if (m == 13) begin
        checkOutput("hand_dig_m13", {2'b00, digSel}, 8'h3D);
        checkOutput("hand_seg_m13", {1'b0, seg}, 8'h12);
      end
      if (m == 60 || m == 120) begin
        checkOutput($sformatf("hand_fd_m%0d", m), {7'b0, frameDone}, 8'h01);
      end
      if (m == 30) begin
        checkOutput("hand_antitear_m30", {1'b0, seg}, 8'h19);
      end
      if (m == 65) begin
        checkOutput("hand_nines_m65", {1'b0, seg}, 8'h18);
      end
    end

    $display("[TB] invalid bcd");
    for (int m = 1; m <= 60; m++) begin
      applyStimulus(1'b0, 1'b1, 24'h00000A);
      checkScan("inval", m, 24'h00000A);
      if (m == 5) begin
        checkOutput("hand_dash_m5", {1'b0, seg}, 8'h3F);
      end
    end

    $display("[TB] leading digit zero");
    for (int m = 1; m <= 60; m++) begin
      applyStimulus(1'b0, 1'b1, 24'h012345);
      checkScan("lz", m, 24'h012345);
      if (m == 53) begin
`ifdef SEG_SCAN_LZ_BLANK_EN
        checkOutput("hand_lz_dig_m53", {2'b00, digSel}, 8'h3F);
        checkOutput("hand_lz_seg_m53", {1'b0, seg}, 8'h7F);
`else
        checkOutput("hand_lz_dig_m53", {2'b00, digSel}, 8'h1F);
        checkOutput("hand_lz_seg_m53", {1'b0, seg}, 8'h40);
`endif
      end
    end

    $display("[TB] enable toggle");
    for (int m = 1; m <= 34; m++) begin
      applyStimulus(1'b0, 1'b1, 24'h012345);
      checkScan("pre_off", m, 24'h012345);
    end
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1'b0, 1'b0, 24'h000777);
      checkDark($sformatf("en_off%0d", n));
    end
    for (int m = 1; m <= 60; m++) begin
      applyStimulus(1'b0, 1'b1, 24'h000777);
      checkScan("restart", m, 24'h000777);
      if (m == 3) begin
        checkOutput("hand_restart_dig_m3", {2'b00, digSel}, 8'h3E);
        checkOutput("hand_restart_seg_m3", {1'b0, seg}, 8'h78);
      end
    end

    $display("[TB] reset mid-slot");
    for (int m = 1; m <= 15; m++) begin
      applyStimulus(1'b0, 1'b1, 24'h000777);
      checkScan("pre_rst", m, 24'h000777);
    end
    applyStimulus(1'b1, 1'b1, 24'h000777);
    checkDark("mid_rst");
    for (int m = 1; m <= 20; m++) begin
      applyStimulus(1'b0, 1'b1, 24'h654321);
      checkScan("post_rst", m, 24'h654321);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
